// File: rtl/if_stage_fetch.sv
// -----------------------------------------------------------------------------
// if_stage_fetch
//   Instruction-fetch stage of the 5-stage ARM pipeline. Holds the PC, reads a
//   word-addressed instruction ROM with a configurable number of wait states,
//   and owns the IF/ID pipeline register that feeds the decode stage.
//
// Parameters
//   ADDR_W        ROM index width, depth = 2**ADDR_W words
//   IMEM_LATENCY  extra wait cycles per fetch (0 = one word per cycle)
//   IMEM_FILE     name of the hex image preloaded into imem by the
//                 simulation/implementation load flow (the RTL never writes imem)
//
// Ports
//   clk_i            pipeline clock, rising edge
//   rst_i            asynchronous, active-high reset
//   hazard_i         freeze: PC and IF/ID register hold
//   branch_taken_i   redirect PC to branch_addr_i and squash the fetch in flight
//   branch_addr_i    branch target byte address (bits [1:0] ignored)
//   pc_o             IF/ID: byte address of fetched instruction + 4
//   instruction_o    IF/ID: fetched instruction word
//   valid_o          IF/ID: 1 = real instruction, 0 = bubble
//   fetch_count_o    committed fetches        (IF_PERF_CNT_EN only)
//   bubble_count_o   bubbles loaded into IF/ID (IF_PERF_CNT_EN only)
//
// Configuration macro
//   IF_PERF_CNT_EN   adds the fetch/bubble performance counters and their ports.
// -----------------------------------------------------------------------------
module if_stage_fetch #(
  parameter int    ADDR_W       = 8,
  parameter int    IMEM_LATENCY = 0,
  parameter string IMEM_FILE    = "imem.hex"
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hazard_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_addr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic        valid_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count_o,
  output logic [31:0] bubble_count_o
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = (IMEM_LATENCY < 1) ? 1 : $clog2(IMEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(IMEM_LATENCY);
  // The image name only matters to the load flow.
  localparam int unused_imem_file_bits = $bits(IMEM_FILE);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  // Instruction ROM, contents supplied by the load flow.
  logic [31:0] imem [DEPTH];

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   wait_cnt_q,  wait_cnt_d;
  logic [31:0]        held_word_q, held_word_d;
  logic [31:0]        pc_q,        pc_d;
  logic [31:0]        id_pc_q,     id_pc_d;
  logic [31:0]        id_instr_q,  id_instr_d;
  logic               id_valid_q,  id_valid_d;

  logic [31:0] rom_word_s;
  logic [31:0] word_s;
  logic        word_ready_s;
  logic        commit_s;
  logic        bubble_s;
  logic        unused_addr_lsb_s;

  // Index wraps naturally because only ADDR_W bits of the word address are used.
  assign rom_word_s        = imem[pc_q[ADDR_W+1:2]];
  assign unused_addr_lsb_s = ^branch_addr_i[1:0];

  // Next-state: wait-state sequencing, then IF/ID priority branch > hazard > commit > bubble.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    held_word_d  = held_word_q;
    pc_d         = pc_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    id_valid_d   = id_valid_q;
    word_ready_s = 1'b0;
    word_s       = rom_word_s;
    commit_s     = 1'b0;
    bubble_s     = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (IMEM_LATENCY == 0) begin
          word_ready_s = 1'b1;
        end else begin
          wait_cnt_d = LAT_INIT;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // The ROM keeps counting even while the pipeline is frozen.
        wait_cnt_d = wait_cnt_q - CNT_W'(1);
        if (wait_cnt_q == CNT_W'(1)) begin
          word_ready_s = 1'b1;
          if (hazard_i) begin
            state_d     = S_HOLD;
            held_word_d = rom_word_s;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          word_ready_s = 1'b0;
        end
      end
      S_HOLD: begin
        word_ready_s = 1'b1;
        word_s       = held_word_q;
        if (!hazard_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d    = S_FETCH;
        wait_cnt_d = '0;
      end
    endcase

    if (branch_taken_i) begin
      // Redirect wins over everything and abandons any pending or latched word.
      pc_d       = {branch_addr_i[31:2], 2'b00};
      id_pc_d    = 32'd0;
      id_instr_d = 32'd0;
      id_valid_d = 1'b0;
      state_d    = S_FETCH;
      wait_cnt_d = '0;
      bubble_s   = 1'b1;
    end else if (hazard_i) begin
      pc_d = pc_q;
    end else if (word_ready_s) begin
      pc_d       = pc_q + 32'd4;
      id_pc_d    = pc_q + 32'd4;
      id_instr_d = word_s;
      id_valid_d = 1'b1;
      commit_s   = 1'b1;
    end else begin
      // Fetch still pending: PC field is left as is, only the payload is killed.
      id_instr_d = 32'd0;
      id_valid_d = 1'b0;
      bubble_s   = 1'b1;
    end
  end

  // Fetch FSM, PC and IF/ID pipeline register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      held_word_q <= 32'd0;
      pc_q        <= 32'd0;
      id_pc_q     <= 32'd0;
      id_instr_q  <= 32'd0;
      id_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      held_word_q <= held_word_d;
      pc_q        <= pc_d;
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
    end
  end

  assign pc_o          = id_pc_q;
  assign instruction_o = id_instr_q;
  assign valid_o       = id_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] bubble_cnt_q;

  // Performance counters; both hold under hazard because neither event fires.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_q  <= 32'd0;
      bubble_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_q + {31'd0, commit_s};
      bubble_cnt_q <= bubble_cnt_q + {31'd0, bubble_s};
    end
  end

  assign fetch_count_o  = fetch_cnt_q;
  assign bubble_count_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage_fetch.sv
module tb_if_stage_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, hz0, br0, val0;
  logic [31:0] ba0, pc0, ins0;
  logic        rst2, hz2, br2, val2;
  logic [31:0] ba2, pc2, ins2;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fc0, bc0, fc2, bc2;
`endif

  if_stage_fetch #(.ADDR_W(8), .IMEM_LATENCY(0), .IMEM_FILE("imem.hex")) dut0 (
    .clk_i(clk), .rst_i(rst0), .hazard_i(hz0), .branch_taken_i(br0),
    .branch_addr_i(ba0), .pc_o(pc0), .instruction_o(ins0), .valid_o(val0)
`ifdef IF_PERF_CNT_EN
    , .fetch_count_o(fc0), .bubble_count_o(bc0)
`endif
  );

  if_stage_fetch #(.ADDR_W(8), .IMEM_LATENCY(2), .IMEM_FILE("imem.hex")) dut2 (
    .clk_i(clk), .rst_i(rst2), .hazard_i(hz2), .branch_taken_i(br2),
    .branch_addr_i(ba2), .pc_o(pc2), .instruction_o(ins2), .valid_o(val2)
`ifdef IF_PERF_CNT_EN
    , .fetch_count_o(fc2), .bubble_count_o(bc2)
`endif
  );

  typedef struct {
    logic        hz;
    logic        br;
    logic [31:0] ba;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_val;
    logic        c_pc;
  } vec_t;

  vec_t t0[17];
  vec_t t2[27];
  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] w(input int idx);
    return 32'hC0DE_0000 + 32'(idx) * 32'h0000_0101;
  endfunction

  function automatic vec_t mk(input logic hz, input logic br, input logic [31:0] ba,
                              input logic [31:0] e_pc, input logic [31:0] e_ins,
                              input logic e_val, input logic c_pc);
    vec_t v;
    v.hz = hz; v.br = br; v.ba = ba; v.e_pc = e_pc;
    v.e_ins = e_ins; v.e_val = e_val; v.c_pc = c_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one row, clock it, sample 1 time unit after the edge.
  task automatic apply(input int d, input vec_t v, input string tag);
    logic [31:0] a_pc, a_ins;
    logic        a_val;
    if (d == 0) begin
      hz0 = v.hz; br0 = v.br; ba0 = v.ba;
    end else begin
      hz2 = v.hz; br2 = v.br; ba2 = v.ba;
    end
    @(posedge clk);
    #1;
    if (d == 0) begin
      a_pc = pc0; a_ins = ins0; a_val = val0;
    end else begin
      a_pc = pc2; a_ins = ins2; a_val = val2;
    end
    if (v.c_pc) chk({tag, " pc"}, a_pc, v.e_pc);
    chk({tag, " instr"}, a_ins, v.e_ins);
    chk({tag, " valid"}, {31'd0, a_val}, {31'd0, v.e_val});
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic rst_pulse(input int d, input string tag);
    if (d == 0) begin
      hz0 = 1'b0; br0 = 1'b0;
      #3 rst0 = 1'b1;
      #1;
      chk({tag, " pc"}, pc0, 32'd0);
      chk({tag, " instr"}, ins0, 32'd0);
      chk({tag, " valid"}, {31'd0, val0}, 32'd0);
`ifdef IF_PERF_CNT_EN
      chk({tag, " fetchCount"}, fc0, 32'd0);
      chk({tag, " bubbleCount"}, bc0, 32'd0);
`endif
      #1 rst0 = 1'b0;
    end else begin
      hz2 = 1'b0; br2 = 1'b0;
      #3 rst2 = 1'b1;
      #1;
      chk({tag, " pc"}, pc2, 32'd0);
      chk({tag, " instr"}, ins2, 32'd0);
      chk({tag, " valid"}, {31'd0, val2}, 32'd0);
`ifdef IF_PERF_CNT_EN
      chk({tag, " fetchCount"}, fc2, 32'd0);
      chk({tag, " bubbleCount"}, bc2, 32'd0);
`endif
      #1 rst2 = 1'b0;
    end
  endtask

  initial begin
    rst0 = 1'b1; hz0 = 1'b0; br0 = 1'b0; ba0 = 32'd0;
    rst2 = 1'b1; hz2 = 1'b0; br2 = 1'b0; ba2 = 32'd0;
    for (int i = 0; i < 256; i++) begin
      dut0.imem[i] = w(i);
      dut2.imem[i] = w(i);
    end

    // Latency 0: stream, 3-cycle freeze, branches, PC wrap, ROM index wrap.
    t0[0]  = mk(1'b0, 1'b0, 32'h0,         32'd4,         w(0),   1'b1, 1'b1);
    t0[1]  = mk(1'b0, 1'b0, 32'h0,         32'd8,         w(1),   1'b1, 1'b1);
    t0[2]  = mk(1'b1, 1'b0, 32'h0,         32'd8,         w(1),   1'b1, 1'b1);
    t0[3]  = mk(1'b1, 1'b0, 32'h0,         32'd8,         w(1),   1'b1, 1'b1);
    t0[4]  = mk(1'b1, 1'b0, 32'h0,         32'd8,         w(1),   1'b1, 1'b1);
    t0[5]  = mk(1'b0, 1'b0, 32'h0,         32'd12,        w(2),   1'b1, 1'b1);
    t0[6]  = mk(1'b0, 1'b0, 32'h0,         32'd16,        w(3),   1'b1, 1'b1);
    t0[7]  = mk(1'b1, 1'b1, 32'h40,        32'd0,         32'd0,  1'b0, 1'b1);
    t0[8]  = mk(1'b0, 1'b0, 32'h0,         32'h44,        w(16),  1'b1, 1'b1);
    t0[9]  = mk(1'b0, 1'b1, 32'h83,        32'd0,         32'd0,  1'b0, 1'b1);
    t0[10] = mk(1'b0, 1'b0, 32'h0,         32'h84,        w(32),  1'b1, 1'b1);
    t0[11] = mk(1'b0, 1'b1, 32'hFFFF_FFFC, 32'd0,         32'd0,  1'b0, 1'b1);
    t0[12] = mk(1'b0, 1'b0, 32'h0,         32'h0,         w(255), 1'b1, 1'b1);
    t0[13] = mk(1'b0, 1'b0, 32'h0,         32'd4,         w(0),   1'b1, 1'b1);
    t0[14] = mk(1'b0, 1'b1, 32'h404,       32'd0,         32'd0,  1'b0, 1'b1);
    t0[15] = mk(1'b0, 1'b0, 32'h0,         32'h408,       w(1),   1'b1, 1'b1);
    t0[16] = mk(1'b0, 1'b0, 32'h0,         32'd4,         w(0),   1'b1, 1'b1);

    // Latency 2: cadence, HOLD on hazard, branch in WAIT and in HOLD.
    t2[0]  = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b1);
    t2[1]  = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b1);
    t2[2]  = mk(1'b0, 1'b0, 32'h0,  32'd4,  w(0),  1'b1, 1'b1);
    t2[3]  = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b0);
    t2[4]  = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b0);
    t2[5]  = mk(1'b0, 1'b0, 32'h0,  32'd8,  w(1),  1'b1, 1'b1);
    t2[6]  = mk(1'b1, 1'b0, 32'h0,  32'd8,  w(1),  1'b1, 1'b1);
    t2[7]  = mk(1'b1, 1'b0, 32'h0,  32'd8,  w(1),  1'b1, 1'b1);
    t2[8]  = mk(1'b1, 1'b0, 32'h0,  32'd8,  w(1),  1'b1, 1'b1);
    t2[9]  = mk(1'b1, 1'b0, 32'h0,  32'd8,  w(1),  1'b1, 1'b1);
    t2[10] = mk(1'b0, 1'b0, 32'h0,  32'd12, w(2),  1'b1, 1'b1);
    t2[11] = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b0);
    t2[12] = mk(1'b1, 1'b1, 32'h40, 32'd0,  32'd0, 1'b0, 1'b1);
    t2[13] = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b1);
    t2[14] = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b1);
    t2[15] = mk(1'b0, 1'b0, 32'h0,  32'h44, w(16), 1'b1, 1'b1);
    t2[16] = mk(1'b1, 1'b0, 32'h0,  32'h44, w(16), 1'b1, 1'b1);
    t2[17] = mk(1'b1, 1'b0, 32'h0,  32'h44, w(16), 1'b1, 1'b1);
    t2[18] = mk(1'b1, 1'b0, 32'h0,  32'h44, w(16), 1'b1, 1'b1);
    t2[19] = mk(1'b1, 1'b1, 32'h80, 32'd0,  32'd0, 1'b0, 1'b1);
    t2[20] = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b1);
    t2[21] = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b1);
    t2[22] = mk(1'b0, 1'b0, 32'h0,  32'h84, w(32), 1'b1, 1'b1);
    t2[23] = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b0);
    t2[24] = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b1);
    t2[25] = mk(1'b0, 1'b0, 32'h0,  32'd0,  32'd0, 1'b0, 1'b1);
    t2[26] = mk(1'b0, 1'b0, 32'h0,  32'd4,  w(0),  1'b1, 1'b1);

    @(posedge clk);
    #1;
    chk("reset L0 pc", pc0, 32'd0);
    chk("reset L0 instr", ins0, 32'd0);
    chk("reset L0 valid", {31'd0, val0}, 32'd0);
    chk("reset L2 pc", pc2, 32'd0);
    chk("reset L2 instr", ins2, 32'd0);
    chk("reset L2 valid", {31'd0, val2}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("reset L0 fetchCount", fc0, 32'd0);
    chk("reset L0 bubbleCount", bc0, 32'd0);
`endif

    rst0 = 1'b0;
    for (int i = 0; i <= 6; i++) apply(0, t0[i], $sformatf("L0 row%0d", i));
`ifdef IF_PERF_CNT_EN
    chk("L0 fetchCount after ABCD", fc0, 32'd4);
    chk("L0 bubbleCount after ABCD", bc0, 32'd0);
`endif
    for (int i = 7; i <= 15; i++) apply(0, t0[i], $sformatf("L0 row%0d", i));
    rst_pulse(0, "L0 async rst");
    apply(0, t0[16], "L0 row16");

    rst2 = 1'b0;
    for (int i = 0; i <= 5; i++) apply(2, t2[i], $sformatf("L2 row%0d", i));
`ifdef IF_PERF_CNT_EN
    chk("L2 fetchCount", fc2, 32'd2);
    chk("L2 bubbleCount", bc2, 32'd4);
`endif
    for (int i = 6; i <= 23; i++) apply(2, t2[i], $sformatf("L2 row%0d", i));
    rst_pulse(2, "L2 async rst mid-WAIT");
    for (int i = 24; i <= 26; i++) apply(2, t2[i], $sformatf("L2 row%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
